uart_cmd_ctrl: RTL and testbench

- Frame sequencer placed after the UART receiver.
- Consumes byte strobes, assembles command frames of the form SYNC, ADDR, LEN, DATA×LEN, CHK, and verifies the XOR checksum.
- Good frames are committed as sequential writes to a downstream 8-bit register file.
- Bad frames are discarded and reported via an error pulse and code.

---
 rtl/uart_cmd_pkg.sv | 22 ++
 rtl/uart_cmd_buf.sv | 33 +++
 rtl/uart_cmd_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared state encoding, error codes and defaults for the UART command sequencer
// Purpose: types and constants imported by uart_cmd_ctrl and its payload buffer.
// Contents: state_e (3-bit frame FSM encoding), err_code values, default SYNC byte.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_LEN    = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHK    = 3'd4,
    ST_COMMIT = 3'd5
  } state_e;

  localparam logic [1:0] ERR_OVERRUN = 2'b00;
  localparam logic [1:0] ERR_LEN     = 2'b01;
  localparam logic [1:0] ERR_CHK     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_cmd_buf.sv
// rtl/uart_cmd_buf.sv - MAX_LEN x 8 payload store for one command frame
// Purpose: holds the payload of the frame being received until it is committed.
// Ports:
//   clk_i     system clock
//   we_i      write enable, written on the rising edge
//   waddr_i   write slot
//   wdata_i   write byte
//   raddr_i   read slot
//   rdata_o   combinational read data
module uart_cmd_buf #(
  parameter int MAX_LEN = 16,
  parameter int AW      = 4
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  // Contents are don't-care after reset, so the array carries no reset.
  logic [7:0] mem_q [MAX_LEN];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - UART command frame sequencer committing checked frames to a register file
// Purpose: assembles SYNC, ADDR, LEN, DATA x LEN, CHK frames from received bytes,
// verifies the XOR checksum over ADDR, LEN and DATA, and replays good payloads
// as sequential register-file writes. Bad frames raise frame_err with a cause.
// Ports:
//   clk_i          system clock
//   rst_n_i        asynchronous active-low reset
//   rx_valid_i     one-cycle strobe, rx_byte_i holds a new byte
//   rx_byte_i      received byte
//   wr_en_o        register-file write strobe
//   wr_addr_o      register-file write address (base + index, mod 256)
//   wr_data_o      register-file write data
//   frame_ok_o     one-cycle pulse, frame committed
//   frame_err_o    one-cycle pulse, error detected
//   err_code_o     cause: 00 overrun, 01 bad length, 10 checksum, 11 timeout
//   busy_o         high whenever the sequencer is not idle
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT,
  parameter int         MAX_LEN      = 16,
  parameter int         TIMEOUT_CLKS = 2000000
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       rx_valid_i,
  input  logic [7:0] rx_byte_i,
  output logic       wr_en_o,
  output logic [7:0] wr_addr_o,
  output logic [7:0] wr_data_o,
  output logic       frame_ok_o,
  output logic       frame_err_o,
  output logic [1:0] err_code_o,
  output logic       busy_o
);

  localparam int IDX_W = $clog2(MAX_LEN) + 1;
  localparam int AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW    = $clog2(TIMEOUT_CLKS);

  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [TW-1:0]    TMO_ONE   = TW'(1);
  localparam logic [TW-1:0]    TMO_LAST  = TW'(TIMEOUT_CLKS - 1);
  localparam logic [8:0]       MAX_LEN_9 = 9'(MAX_LEN);

  state_e           state_q, state_d;
  logic [7:0]       base_q, base_d;
  logic [IDX_W-1:0] len_q, len_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       chk_q, chk_d;
  logic [TW-1:0]    tmo_q, tmo_d;

  logic             wr_en_q, wr_en_d;
  logic [7:0]       wr_addr_q, wr_addr_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic             frame_ok_q, frame_ok_d;
  logic             frame_err_q, frame_err_d;
  logic [1:0]       err_code_q, err_code_d;
  logic             busy_q, busy_d;

  logic             buf_we;
  logic [7:0]       buf_rdata;
  logic [IDX_W-1:0] idx_inc;
  logic             in_frame;

  assign idx_inc  = idx_q + IDX_ONE;
  assign in_frame = (state_q == ST_ADDR) || (state_q == ST_LEN) ||
                    (state_q == ST_DATA) || (state_q == ST_CHK);

  // idx_q is cleared on entry to CHK, so the read port already presents
  // slot 0 when the checksum byte arrives and the first write can be
  // issued on the very next cycle.
  uart_cmd_buf #(
    .MAX_LEN (MAX_LEN),
    .AW      (AW)
  ) u_buf (
    .clk_i   (clk_i),
    .we_i    (buf_we),
    .waddr_i (idx_q[AW-1:0]),
    .wdata_i (rx_byte_i),
    .raddr_i (idx_q[AW-1:0]),
    .rdata_o (buf_rdata)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      chk_q       <= '0;
      tmo_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      chk_q       <= chk_d;
      tmo_q       <= tmo_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    idx_d       = idx_q;
    chk_d       = chk_q;
    tmo_d       = '0;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    buf_we      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rx_valid_i && (rx_byte_i == SYNC_BYTE)) begin
          state_d = ST_ADDR;
          chk_d   = '0;
        end
      end

      ST_ADDR: begin
        if (rx_valid_i) begin
          base_d  = rx_byte_i;
          chk_d   = chk_q ^ rx_byte_i;
          state_d = ST_LEN;
        end
      end

      ST_LEN: begin
        if (rx_valid_i) begin
          if ((rx_byte_i == 8'd0) || ({1'b0, rx_byte_i} > MAX_LEN_9)) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_LEN;
            state_d     = ST_IDLE;
          end else begin
            len_d   = IDX_W'(rx_byte_i);
            chk_d   = chk_q ^ rx_byte_i;
            idx_d   = '0;
            state_d = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        if (rx_valid_i) begin
          buf_we = 1'b1;
          chk_d  = chk_q ^ rx_byte_i;
          if (idx_inc == len_q) begin
            idx_d   = '0;
            state_d = ST_CHK;
          end else begin
            idx_d = idx_inc;
          end
        end
      end

      ST_CHK: begin
        if (rx_valid_i) begin
          if (rx_byte_i == chk_q) begin
            // First write leaves with the COMMIT transition; idx then
            // tracks the slot of the next write to issue.
            state_d   = ST_COMMIT;
            wr_en_d   = 1'b1;
            wr_addr_d = base_q;
            wr_data_d = buf_rdata;
            idx_d     = IDX_ONE;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_CHK;
            state_d     = ST_IDLE;
          end
        end
      end

      ST_COMMIT: begin
        if (idx_q == len_q) begin
          frame_ok_d = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = base_q + 8'(idx_q);
          wr_data_d = buf_rdata;
          idx_d     = idx_inc;
        end
        // A byte arriving now cannot be held; it is dropped and flagged
        // while the commit carries on.
        if (rx_valid_i) begin
          frame_err_d = 1'b1;
          err_code_d  = ERR_OVERRUN;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Inter-byte watchdog; a byte on the expiry cycle takes priority.
    if (in_frame && !rx_valid_i) begin
      if (tmo_q == TMO_LAST) begin
        frame_err_d = 1'b1;
        err_code_d  = ERR_TIMEOUT;
        state_d     = ST_IDLE;
      end else begin
        tmo_d = tmo_q + TMO_ONE;
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  assign wr_en_o     = wr_en_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign frame_ok_o  = frame_ok_q;
  assign frame_err_o = frame_err_q;
  assign err_code_o  = err_code_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb/tb_uart_cmd_ctrl.sv - self-checking bench for uart_cmd_ctrl
module tb_uart_cmd_ctrl;

  localparam int         MAX_LEN = 16;
  localparam int         TMO     = 40;
  localparam logic [7:0] SYNC    = 8'hA5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;

  always #5 clk = ~clk;

  uart_cmd_ctrl #(
    .SYNC_BYTE    (SYNC),
    .MAX_LEN      (MAX_LEN),
    .TIMEOUT_CLKS (TMO)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .rx_valid_i  (rx_valid),
    .rx_byte_i   (rx_byte),
    .wr_en_o     (wr_en),
    .wr_addr_o   (wr_addr),
    .wr_data_o   (wr_data),
    .frame_ok_o  (frame_ok),
    .frame_err_o (frame_err),
    .err_code_o  (err_code),
    .busy_o      (busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed events, sampled on the falling edge.
  logic [15:0] wq[$];
  int          wcyc[$];
  logic [1:0]  eq[$];
  int          ok_cnt;
  int          ok_cyc;

  always @(negedge clk) begin
    if (wr_en) begin
      wq.push_back({wr_addr, wr_data});
      wcyc.push_back(cyc);
    end
    if (frame_ok) begin
      ok_cnt = ok_cnt + 1;
      ok_cyc = cyc;
    end
    if (frame_err) eq.push_back(err_code);
  end

  int n_checks = 0;
  int n_fail   = 0;
  int last_edge;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    wq.delete();
    wcyc.delete();
    eq.delete();
    ok_cnt = 0;
    ok_cyc = -1;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(posedge clk);
    #1;
    last_edge = cyc;
    rx_valid  = 1'b0;
    rx_byte   = 8'($urandom);
    tick(gap);
  endtask

  // Frame-level reference: locate SYNC, read ADDR/LEN, apply length and
  // XOR-checksum rules, list the writes a good frame produces.
  logic [7:0]  fq[$];
  logic [15:0] exp_w[$];
  int          exp_ok;
  int          exp_err;

  task automatic model_frame();
    int i;
    int addr;
    int len;
    logic [7:0] c;
    exp_w.delete();
    exp_ok  = 0;
    exp_err = -1;
    i = 0;
    while (i < fq.size() && fq[i] != SYNC) i++;
    if (i + 2 >= fq.size()) return;
    addr = fq[i+1];
    len  = fq[i+2];
    if (len == 0 || len > MAX_LEN) begin
      exp_err = 1;
      return;
    end
    c = fq[i+1] ^ fq[i+2];
    for (int k = 0; k < len; k++) c = c ^ fq[i+3+k];
    if (fq[i+3+len] == c) begin
      for (int k = 0; k < len; k++) exp_w.push_back({8'((addr + k) % 256), fq[i+3+k]});
      exp_ok = 1;
    end else begin
      exp_err = 2;
    end
  endtask

  task automatic compare_model(input string name, input int chk_edge, input int n_extra_err);
    model_frame();
    check($sformatf("%s nwrites", name), wq.size(), exp_w.size());
    for (int k = 0; k < exp_w.size() && k < wq.size(); k++)
      check($sformatf("%s write%0d", name, k), wq[k], exp_w[k]);
    check($sformatf("%s frame_ok", name), ok_cnt, exp_ok);
    check($sformatf("%s nerr", name), eq.size(), ((exp_err >= 0) ? 1 : 0) + n_extra_err);
    if (exp_err >= 0 && eq.size() > 0)
      check($sformatf("%s err_code", name), eq[eq.size()-1], exp_err);
    if (exp_ok == 1 && wcyc.size() > 0) begin
      check($sformatf("%s first write cycle", name), wcyc[0], chk_edge);
      check($sformatf("%s frame_ok cycle", name), ok_cyc, chk_edge + exp_w.size());
    end
    check($sformatf("%s busy idle", name), busy, 0);
  endtask

  function automatic void build_frame(input logic [7:0] base, input int len, input bit good);
    logic [7:0] c;
    fq.delete();
    fq.push_back(SYNC);
    fq.push_back(base);
    fq.push_back(8'(len));
    c = base ^ 8'(len);
    for (int k = 0; k < len; k++) begin
      fq.push_back(8'($urandom));
      c = c ^ fq[fq.size()-1];
    end
    fq.push_back(good ? c : (c ^ 8'($urandom_range(255, 1))));
  endfunction

  typedef struct {
    logic [7:0] b[8];
    int         n;
    int         exp_nw;
    int         exp_ok;
    int         exp_err;
    logic [31:0] fl;   // {first addr, first data, last addr, last data}
  } vec_t;

  function automatic vec_t mkv(input logic [63:0] bs, input int n, input int nw,
                               input int ok, input int err, input logic [31:0] fl);
    vec_t v;
    for (int k = 0; k < 8; k++) v.b[k] = bs[63-8*k -: 8];
    v.n = n; v.exp_nw = nw; v.exp_ok = ok; v.exp_err = err; v.fl = fl;
    return v;
  endfunction

  vec_t tv[9];

  initial begin
    int first_err;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    clear_mon();

    tv[0] = mkv(64'hA5_10_03_11_22_33_13_00, 7, 3, 1, -1, 32'h10_11_12_33);
    tv[1] = mkv(64'hA5_FE_02_AA_BB_ED_00_00, 6, 2, 1, -1, 32'hFE_AA_FF_BB);
    tv[2] = mkv(64'hA5_FF_02_01_02_FE_00_00, 6, 2, 1, -1, 32'hFF_01_00_02);
    tv[3] = mkv(64'hA5_00_01_55_00_00_00_00, 5, 0, 0,  2, 32'h0);
    tv[4] = mkv(64'hA5_40_01_77_36_00_00_00, 5, 1, 1, -1, 32'h40_77_40_77);
    tv[5] = mkv(64'hA5_00_00_00_00_00_00_00, 3, 0, 0,  1, 32'h0);
    tv[6] = mkv(64'hA5_00_11_00_00_00_00_00, 3, 0, 0,  1, 32'h0);
    tv[7] = mkv(64'hA5_30_02_A5_5A_CD_00_00, 6, 2, 1, -1, 32'h30_A5_31_5A);
    tv[8] = mkv(64'h00_FF_A5_50_01_99_C8_00, 7, 1, 1, -1, 32'h50_99_50_99);

    // Reset state
    tick(3);
    check("reset outputs", {wr_en, wr_addr, wr_data, frame_ok, frame_err, err_code, busy}, 0);
    rst_n = 1'b1;
    tick(2);
    check("idle busy", busy, 0);

    // Directed table
    for (int v = 0; v < 9; v++) begin
      clear_mon();
      for (int k = 0; k < tv[v].n; k++) send_byte(tv[v].b[k], 0);
      tick(MAX_LEN + 4);
      check($sformatf("vec%0d nwrites", v), wq.size(), tv[v].exp_nw);
      check($sformatf("vec%0d frame_ok", v), ok_cnt, tv[v].exp_ok);
      check($sformatf("vec%0d nerr", v), eq.size(), (tv[v].exp_err >= 0) ? 1 : 0);
      if (tv[v].exp_err >= 0 && eq.size() > 0)
        check($sformatf("vec%0d err_code", v), eq[0], tv[v].exp_err);
      if (tv[v].exp_nw > 0 && wq.size() > 0) begin
        check($sformatf("vec%0d first write", v), wq[0], tv[v].fl[31:16]);
        check($sformatf("vec%0d last write", v), wq[wq.size()-1], tv[v].fl[15:0]);
      end
      check($sformatf("vec%0d busy", v), busy, 0);
    end

    // Timeout: silence after ADDR expires exactly TMO cycles later
    clear_mon();
    send_byte(SYNC, 0);
    send_byte(8'h20, 0);
    first_err = -1;
    for (int k = 1; k <= TMO + 2; k++) begin
      tick(1);
      if (frame_err && first_err < 0) first_err = k;
    end
    check("timeout cycle", first_err, TMO);
    check("timeout nerr", eq.size(), 1);
    if (eq.size() > 0) check("timeout code", eq[0], 3);
    check("timeout busy", busy, 0);

    // Byte on the expiry cycle wins over the timeout
    clear_mon();
    send_byte(SYNC, 0);
    send_byte(8'h20, 0);
    tick(TMO - 1);
    send_byte(8'h01, 0);
    send_byte(8'h42, 0);
    send_byte(8'h63, 0);
    tick(25);
    check("expiry race nerr", eq.size(), 0);
    check("expiry race nwrites", wq.size(), 1);
    if (wq.size() > 0) check("expiry race write", wq[0], 16'h2042);
    check("expiry race ok", ok_cnt, 1);

    // Max-length frame with an overrun byte during COMMIT, wrapping past FF
    clear_mon();
    build_frame(8'hF8, MAX_LEN, 1'b1);
    for (int k = 0; k < fq.size() - 1; k++) send_byte(fq[k], 0);
    send_byte(fq[fq.size()-1], 2);
    first_err = last_edge;
    send_byte(SYNC, 0);
    tick(25);
    compare_model("overrun", first_err, 1);
    if (eq.size() > 0) check("overrun code", eq[0], 0);

    // Reset during COMMIT stops writes at once
    clear_mon();
    build_frame(8'h80, MAX_LEN, 1'b1);
    for (int k = 0; k < fq.size(); k++) send_byte(fq[k], 0);
    tick(5);
    rst_n = 1'b0;
    #1;
    check("mid-commit reset outputs", {wr_en, wr_addr, wr_data, frame_ok, frame_err, err_code, busy}, 0);
    check("writes before reset", wq.size(), 5);
    model_frame();
    for (int k = 0; k < 5 && k < wq.size(); k++)
      check($sformatf("pre-reset write%0d", k), wq[k], exp_w[k]);
    tick(3);
    rst_n = 1'b1;
    tick(25);
    check("writes after reset", wq.size(), 5);
    check("no frame_ok after reset", ok_cnt, 0);
    check("no err after reset", eq.size(), 0);
    check("busy after reset", busy, 0);

    // Random frames against the reference model
    for (int r = 0; r < 30; r++) begin
      int len;
      clear_mon();
      if ($urandom_range(9, 0) == 0) begin
        len = ($urandom_range(1, 0) == 0) ? 0 : $urandom_range(255, MAX_LEN + 1);
        fq.delete();
        fq.push_back(SYNC);
        fq.push_back(8'($urandom));
        fq.push_back(8'(len));
      end else begin
        len = $urandom_range(MAX_LEN, 1);
        build_frame(8'($urandom), len, $urandom_range(4, 0) != 0);
      end
      for (int k = 0; k < fq.size(); k++) send_byte(fq[k], $urandom_range(3, 0));
      tick(MAX_LEN + 4);
      compare_model($sformatf("rand%0d", r), last_edge, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
